// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and FSM encodings for mmio_uart.
// Holds no logic apart from the divisor clamp helper.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_FRAME    = 6;
  localparam int ST_TX_OVF   = 7;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // RX needs div/2 >= 2 for its start-bit midpoint check.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, head visible combinationally; push/pop take effect on the clock edge.
// Full+push is dropped unless a pop occurs the same cycle; pop on empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// MMIO 8N1 UART: TXDATA/RXDATA/STATUS/BAUDDIV, 1-cycle registered reads, drops on full FIFOs.
// RX path (synchronizer, RX FSM, RX FIFO) is built only when MMIO_UART_RX_EN is defined.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_address,
  input  logic        in_write_en,
  input  logic [31:0] in_write_data,
  output logic [31:0] out_read_data,
  output logic        out_txd,
  input  logic        in_rxd
);

  logic [1:0]  w_reg;
  logic        w_wr_tx;
  logic        w_wr_st;
  logic        w_wr_baud;
  logic        w_unused;

  logic [15:0] r_baud;
  logic        r_tx_ovf;
  logic [31:0] r_rdata;
  logic [7:0]  w_status;

  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_tx_head;
  logic        w_tx_pop;
  logic        w_tx_bit_end;
  logic        w_tx_ovf_set;

  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [15:0] r_tx_div;
  logic [7:0]  r_tx_shreg;
  logic [2:0]  r_tx_bit;
  logic        r_txd;
  logic        r_tx_busy;

  logic        w_rx_valid;
  logic        w_rx_full;
  logic        w_rx_ovr;
  logic        w_frame_err;
  logic [7:0]  w_rx_head;

  assign w_reg     = in_address[3:2];
  assign w_wr_tx   = in_write_en && (w_reg == REG_TXDATA);
  assign w_wr_st   = in_write_en && (w_reg == REG_STATUS);
  assign w_wr_baud = in_write_en && (w_reg == REG_BAUDDIV);
  assign w_unused  = ^{in_address[31:4], in_address[1:0], in_write_data[31:16]};

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_wr_tx),
    .i_pop   (w_tx_pop),
    .i_dat   (in_write_data[7:0]),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);
  // Popping on the last STOP cycle chains the next frame with no idle gap.
  assign w_tx_pop     = !w_tx_empty &&
                        ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_bit_end));
  assign w_tx_ovf_set = w_wr_tx && w_tx_full && !w_tx_pop;

  // Line and busy are registered from the current state, so both trail the state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= MIN_DIV;
      r_tx_shreg <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_busy <= (r_tx_state != TX_IDLE);
      case (r_tx_state)
        TX_IDLE: begin
          r_txd <= 1'b1;
          if (w_tx_pop) begin
            r_tx_shreg <= w_tx_head;
            r_tx_div   <= r_baud;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          r_txd <= 1'b0;
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          r_txd <= r_tx_shreg[0];
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_shreg <= {1'b0, r_tx_shreg[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          r_txd <= 1'b1;
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shreg <= w_tx_head;
              r_tx_div   <= r_baud;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign out_txd = r_txd;

`ifdef MMIO_UART_RX_EN
  logic        r_rxd_s1;
  logic        r_rxd_s2;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_rx_div;
  logic [7:0]  r_rx_shreg;
  logic [2:0]  r_rx_bit;
  logic        r_rx_ovr;
  logic        r_frame_err;
  logic        w_rx_empty;
  logic        w_rx_pop;
  logic        w_rx_push;
  logic        w_rx_ferr_set;
  logic        w_rx_ovr_set;
  logic        w_rx_half_end;
  logic        w_rx_bit_end;
  logic        w_rx_stop_smp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= in_rxd;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  assign w_rx_half_end = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
  assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_stop_smp = (r_rx_state == RX_STOP) && w_rx_bit_end;
  assign w_rx_push     = w_rx_stop_smp && r_rxd_s2;
  assign w_rx_ferr_set = w_rx_stop_smp && !r_rxd_s2;
  assign w_rx_pop      = w_wr_st && in_write_data[0];
  assign w_rx_ovr_set  = w_rx_push && w_rx_full && !w_rx_pop;

  // The falling edge is taken as the cycle the synchronized line first reads low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= MIN_DIV;
      r_rx_shreg <= '0;
      r_rx_bit   <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rxd_s2 && !r_rxd_s1) begin
            r_rx_div   <= r_baud;
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_half_end) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shreg <= {r_rxd_s2, r_rx_shreg[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_dat   (r_rx_shreg),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_rx_ovr_set)                                r_rx_ovr <= 1'b1;
      else if (w_wr_st && in_write_data[ST_RX_OVR])    r_rx_ovr <= 1'b0;
      if (w_rx_ferr_set)                               r_frame_err <= 1'b1;
      else if (w_wr_st && in_write_data[ST_FRAME])     r_frame_err <= 1'b0;
    end
  end

  assign w_rx_valid  = !w_rx_empty;
  assign w_rx_ovr    = r_rx_ovr;
  assign w_frame_err = r_frame_err;
`else
  logic w_unused_rx;

  assign w_unused_rx = in_rxd;
  assign w_rx_valid  = 1'b0;
  assign w_rx_full   = 1'b0;
  assign w_rx_ovr    = 1'b0;
  assign w_frame_err = 1'b0;
  assign w_rx_head   = 8'h00;
`endif

  // Sticky flags: a set on the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud   <= 16'(DEFAULT_DIV);
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_wr_baud) r_baud <= clamp_div(in_write_data[15:0]);
      if (w_tx_ovf_set)                              r_tx_ovf <= 1'b1;
      else if (w_wr_st && in_write_data[ST_TX_OVF])  r_tx_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_VALID] = w_rx_valid;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_BUSY]  = r_tx_busy;
    w_status[ST_RX_OVR]   = w_rx_ovr;
    w_status[ST_FRAME]    = w_frame_err;
    w_status[ST_TX_OVF]   = r_tx_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else begin
      case (w_reg)
        REG_TXDATA:  r_rdata <= '0;
        REG_RXDATA:  r_rdata <= {23'b0, w_rx_valid, w_rx_head};
        REG_STATUS:  r_rdata <= {24'b0, w_status};
        REG_BAUDDIV: r_rdata <= {16'b0, r_baud};
        default:     r_rdata <= '0;
      endcase
    end
  end

  assign out_read_data = r_rdata;

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register access, TX framing, back-to-back TX, RX (when built), reset abort.
`timescale 1ns/1ps
module tb_mmio_uart;

  localparam int TB_DIV = 8;
  localparam logic [31:0] A_TX = 32'h0;
  localparam logic [31:0] A_RX = 32'h4;
  localparam logic [31:0] A_ST = 32'h8;
  localparam logic [31:0] A_BD = 32'hC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] in_address = '0;
  logic        in_write_en = 1'b0;
  logic [31:0] in_write_data = '0;
  logic [31:0] out_read_data;
  logic        out_txd;
  logic        in_rxd = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_byte[$];
  logic       mon_stop[$];
  int         mon_start[$];

  mmio_uart #(.FIFO_DEPTH(16), .DEFAULT_DIV(868)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_address    (in_address),
    .in_write_en   (in_write_en),
    .in_write_data (in_write_data),
    .out_read_data (out_read_data),
    .out_txd       (out_txd),
    .in_rxd        (in_rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    in_address    = a;
    in_write_data = d;
    in_write_en   = 1'b1;
    @(negedge clk);
    in_write_en   = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    in_address  = a;
    in_write_en = 1'b0;
    @(negedge clk);
    d = out_read_data;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    in_rxd = 1'b0;
    repeat (TB_DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      in_rxd = d[k];
      repeat (TB_DIV) @(negedge clk);
    end
    in_rxd = stop;
    repeat (TB_DIV) @(negedge clk);
    in_rxd = 1'b1;
    repeat (2 * TB_DIV) @(negedge clk);
  endtask

  // Line decoder: samples mid-bit, records byte, stop level and start cycle.
  always begin : uart_mon
    int         s_cyc;
    logic [7:0] b;
    @(negedge clk);
    if (mon_en && out_txd == 1'b0) begin
      s_cyc = cyc;
      repeat (TB_DIV / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (TB_DIV) @(negedge clk);
        b[k] = out_txd;
      end
      repeat (TB_DIV) @(negedge clk);
      mon_byte.push_back(b);
      mon_stop.push_back(out_txd);
      mon_start.push_back(s_cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    int          t0;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", out_txd, 1);
    check_eq("rst_rdata", out_read_data, 0);
    reset_n = 1'b1;

    reg_read(A_ST, rd); check_eq("rst_status", rd, 32'h02);
    reg_read(A_BD, rd); check_eq("rst_baud", rd, 32'd868);
    reg_read(A_RX, rd); check_eq("rst_rxdata", rd, 32'h0);
    reg_read(A_TX, rd); check_eq("rst_txdata", rd, 32'h0);

    reg_write(A_BD, 32'd2);         reg_read(A_BD, rd); check_eq("baud_clamp", rd, 32'd4);
    reg_write(A_BD, 32'h0001_0009); reg_read(A_BD, rd); check_eq("baud_upper", rd, 32'd9);
    reg_write(A_BD, TB_DIV);        reg_read(A_BD, rd); check_eq("baud_8", rd, 32'd8);

    // Single frame 0x55: start bit on line two edges after the write edge.
    frame = {1'b1, 8'h55, 1'b0};
    reg_write(A_TX, 32'h55);
    in_address = A_ST;
    for (int j = -1; j < 82; j++) begin
      @(negedge clk);
      if (j < 0 || j >= 80) check_eq($sformatf("tx55_idle_%0d", j), out_txd, 1);
      else                  check_eq($sformatf("tx55_bit_%0d", j), out_txd, frame[j / TB_DIV]);
      check_eq($sformatf("tx55_busy_%0d", j), out_read_data[4], (j >= 1 && j <= 80));
    end
    reg_read(A_ST, rd); check_eq("tx55_done_status", rd, 32'h02);

    // 18 writes into a 16-deep FIFO while the first byte is already on the line.
    mon_en = 1'b1;
    for (int k = 0; k < 18; k++) reg_write(A_TX, k);
    t0 = 0;
    while (mon_byte.size() < 17 && t0 < 2000) begin
      @(negedge clk);
      t0++;
    end
    repeat (200) @(negedge clk);
    mon_en = 1'b0;
    check_eq("bb_count", mon_byte.size(), 17);
    for (int k = 0; k < mon_byte.size() && k < 17; k++) begin
      check_eq($sformatf("bb_byte_%0d", k), mon_byte[k], k);
      check_eq($sformatf("bb_stop_%0d", k), mon_stop[k], 1);
      if (k > 0) check_eq($sformatf("bb_gap_%0d", k), mon_start[k] - mon_start[k-1], 10 * TB_DIV);
    end
    reg_read(A_ST, rd); check_eq("bb_ovf_status", rd, 32'h82);
    reg_write(A_ST, 32'h80);
    reg_read(A_ST, rd); check_eq("bb_ovf_clear", rd, 32'h02);

`ifdef MMIO_UART_RX_EN
    send_rx(8'hA3, 1'b1);
    reg_read(A_RX, rd); check_eq("rx_data", rd, 32'h1A3);
    reg_read(A_ST, rd); check_eq("rx_status", rd, 32'h06);
    reg_write(A_ST, 32'h01);
    reg_read(A_RX, rd); check_eq("rx_pop_valid", rd[8], 0);
    reg_write(A_ST, 32'h01);
    reg_read(A_ST, rd); check_eq("rx_pop_empty", rd, 32'h02);

    send_rx(8'h3C, 1'b0);
    reg_read(A_ST, rd); check_eq("rx_frame_err", rd, 32'h42);
    reg_write(A_ST, 32'h40);
    reg_read(A_ST, rd); check_eq("rx_frame_clear", rd, 32'h02);

    in_rxd = 1'b0;
    repeat (2) @(negedge clk);
    in_rxd = 1'b1;
    repeat (20 * TB_DIV) @(negedge clk);
    reg_read(A_ST, rd); check_eq("rx_glitch", rd, 32'h02);
`else
    send_rx(8'hA3, 1'b1);
    reg_read(A_RX, rd); check_eq("norx_data", rd, 32'h0);
    reg_read(A_ST, rd); check_eq("norx_status", rd, 32'h02);
`endif

    // Reset while data bit 3 (a zero) of 0x55 is on the line.
    reg_write(A_TX, 32'h55);
    repeat (36) @(negedge clk);
    check_eq("abort_pre_txd", out_txd, 0);
    reset_n = 1'b0;
    #1;
    check_eq("abort_txd", out_txd, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    reg_read(A_ST, rd); check_eq("abort_status", rd, 32'h02);
    reg_read(A_BD, rd); check_eq("abort_baud", rd, 32'd868);
    check_eq("abort_txd_idle", out_txd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped 8N1 UART peripheral on the memory mapper's MMIO port, giving the CPU serial TX/RX through four 32-bit registers. Contains a TX FIFO, an RX FIFO, a programmable baud divider and independent TX/RX bit-level state machines. Sits downstream of the memory mapper (mmio address, write data, write enable in; mmio read data out) and drives the board serial pins.

## Interface

- `FIFO_DEPTH`, default 16: entries per FIFO; must be a power of 2 and at least 2.
- `DEFAULT_DIV`, default 868: reset value of BAUDDIV, giving 115200 baud at 100 MHz.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_address`  in  32  MMIO address; only bits [3:2] are decoded.
- `in_write_en`  in  1  register write strobe, sampled on the clk rising edge.
- `in_write_data`  in  32  write data.
- `out_read_data`  out  32  registered read data.
- `out_txd`  out  1  serial transmit line; idles high.
- `in_rxd`  in  1  serial receive line; asynchronous to `clk`.

## Operation

Register map, selected by `in_address[3:2]`:

- 0x0 TXDATA (W)
  - Pushes `in_write_data[7:0]` into the TX FIFO.
  - If the FIFO is full, the byte is dropped and sticky `tx_overflow` is set.
  - Reads return 0.
- 0x4 RXDATA (R)
  - Returns {23'b0, `rx_valid`, head byte}.
  - Reading has no side effect.
- 0x8 STATUS (R/W)
  - Read bits: 0 `tx_full`, 1 `tx_empty`, 2 `rx_valid`, 3 `rx_full`, 4 `tx_busy`, 5 `rx_overrun`, 6 `frame_err`, 7 `tx_overflow`; all other bits read 0.
  - Write 1 to bit 0: pops the RX FIFO; no effect if it is empty.
  - Write 1 to bits 5, 6 or 7: clears the corresponding sticky flag.
- 0xC BAUDDIV (R/W)
  - Bits [15:0] hold the bit period in clk cycles; upper bits read 0.
  - A written value below 4 is stored as 4.

TX state machine, states IDLE → START → DATA → STOP:

- IDLE: if the TX FIFO is not empty, pop one byte, latch BAUDDIV, go to START.
- START: drive 0 for one bit period.
- DATA: drive 8 data bits, LSB first, one bit period each.
- STOP: drive 1 for one bit period. Then go to START if the FIFO is not empty, otherwise to IDLE.
- `tx_busy` is high in every state except IDLE.

RX path:

- `in_rxd` passes through a 2-flop synchronizer; both flops reset to 1.
- IDLE: a falling edge on the synchronized line moves to START.
- START: wait div/2 cycles, then re-check the line. If it is high, treat it as a glitch and return to IDLE. If it is low, go to DATA.
- DATA: sample 8 bits, one every div cycles, LSB first.
- STOP: sample once.
  - High: push the byte into the RX FIFO.
  - Low: discard the byte and set `frame_err`.
- If the RX FIFO is full at push time, the byte is dropped and `rx_overrun` is set.
- RX latches BAUDDIV when it detects the start bit.

Boundary rules:

- A push and a pop on the same cycle on a full FIFO: push accepted, count unchanged.
- A push and a pop on the same cycle on an empty FIFO: push accepted, and the pop is ignored.
- A BAUDDIV write during a frame takes effect at the next frame.
- A simultaneous sticky set and clear on the same cycle: set wins.

## Timing

- Reset, asynchronous, all outputs and state:
  - `out_txd` = 1, `out_read_data` = 0.
  - Both FIFOs empty; all sticky flags 0; BAUDDIV = `DEFAULT_DIV`.
  - TX and RX state machines in IDLE.
- `out_read_data` is registered from `in_address` at each rising edge: 1-cycle read latency, valid every cycle.
- Register write effects are visible in a read issued on the next cycle.
- TXDATA write to line: the write is sampled on edge N, TX pops on edge N+1, and the start bit appears on `out_txd` after edge N+2.
- TX frame length is exactly 10×div cycles; back-to-back frames leave no idle gap.
- RX bit sampling:
  - Data bit k is sampled div/2 + (k+1)×div cycles after the synchronized falling edge.
  - `rx_valid` rises 1 cycle after the stop-bit sample.
- Reset asserted mid-frame aborts the frame immediately and `out_txd` goes to 1.

## Configuration

- `MMIO_UART_RX_EN` defined: the full RX path is built (synchronizer, RX FSM, RX FIFO).
- `MMIO_UART_RX_EN` undefined:
  - The RX logic is not built and `in_rxd` is ignored.
  - RXDATA reads 0.
  - STATUS bits 2, 3, 5 and 6 read 0; the RX pop and clear writes are ignored.
  - TX behaviour is identical to the defined case.

## Structure

- Shared package `mmio_uart_pkg` holds:
  - Register offset constants.
  - STATUS bit index constants.
  - TX/RX state encodings.
  - Minimum divisor constant (4).
- Sub-module `uart_fifo`:
  - Synchronous FIFO with parameters width and depth; instantiated twice (TX and RX).
  - Ports: push, pop, data in, head data, full, empty.
  - Uses asynchronous active-low reset.

## Test plan

- Reset → `out_txd` = 1; STATUS reads 0x02; BAUDDIV reads 868; RXDATA reads 0.
- BAUDDIV = 8, TXDATA = 0x55:
  - `out_txd` goes low after 2 cycles.
  - The bits after the start bit are 1,0,1,0,1,0,1,0, 8 cycles each, then a high stop bit.
  - `tx_busy` falls 80 cycles after the start bit begins.
- BAUDDIV = 8, 18 back-to-back TXDATA writes of 0x00..0x11:
  - Bytes 0x00..0x10 are transmitted in order with no gaps.
  - STATUS bit 7 = 1; writing STATUS 0x80 clears it.
- Drive 0xA3 as 8N1 at 8 cycles/bit on `in_rxd`:
  - RXDATA reads 0x1A3 and STATUS bit 2 = 1.
  - After writing STATUS 0x01, RXDATA bit 8 = 0.
- Drive a frame with the stop bit low → STATUS bit 6 = 1 and `rx_valid` = 0; writing 0x40 clears bit 6.
- Assert `reset_n` low during TX data bit 3 → `out_txd` = 1 within the same cycle and STATUS reads 0x02 after release.
